score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter BLANK_LZ, default 1, meaning 1 = blank leading zero digits (digit 0 always shown).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port score, input, 10, running score from the score counter stage.
REQ-005 SHALL have port screen, input, 1, high while the start/game-over screen is shown.
REQ-006 SHALL have ports hex0..hex3, output, 7 each, active-low segments {g,f,e,d,c,b,a}; hex0 is the ones digit.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port hi_score, output, 10, best score since rst.

Function
REQ-009 SHALL convert the display source value to 4 BCD digits by iterative shift-add-3 (double dabble), one bit per cycle.
REQ-010 SHALL implement the FSM IDLE -> LOAD -> SHIFT (10 cycles) -> LATCH -> IDLE.
REQ-011 IDLE SHALL move to LOAD when the display source differs from the last converted value, or on the first cycle after rst.
REQ-012 LOAD SHALL capture the source into a 10-bit shift register, clear the 16-bit BCD accumulator, and raise busy.
REQ-013 SHIFT SHALL, per cycle, add 3 to each BCD nibble >= 5 and then shift {bcd, bin} left by 1; it runs exactly 10 cycles, tracked by a 4-bit iteration counter.
REQ-014 LATCH SHALL register the 4 digits and the converted value, drive hex0..hex3 from the latched digits, and drop busy.
REQ-015 Latency SHALL be 13 clk edges from the source change to the updated hex outputs.
REQ-016 A source change during LOAD/SHIFT/LATCH SHALL NOT abort the conversion; the FSM SHALL return to IDLE and then restart, so the final display always matches the final source value.
REQ-017 With BLANK_LZ=1, hex3..hex1 SHALL show 7'b1111111 while the digit and all higher digits are 0; hex0 SHALL never be blanked.
REQ-018 Digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Maximum value 1023 SHALL display 1,0,2,3 with no overflow; there is no wrap handling beyond 10 bits.

Reset
REQ-020 rst SHALL force IDLE, busy=0, latched digits=0, hi_score=0, hex0=1000000, and hex1..hex3=1111111 (or 1000000 when BLANK_LZ=0) on the next edge.
REQ-021 rst mid-conversion SHALL discard the partial result.
REQ-022 screen SHALL NOT reset any state in this block.

Configuration
REQ-023 Macro SCORE_DISPLAY_HIGH_SCORE_EN, when defined: hi_score SHALL load score on any cycle where score > hi_score.
REQ-024 With the macro defined, a simultaneous score increase and screen=1 SHALL still update hi_score.
REQ-025 With the macro defined, the display source SHALL be hi_score while screen=1 and score otherwise.
REQ-026 Without the macro, hi_score SHALL be tied to 0 and the display source SHALL always be score.

Structure
REQ-027 Package score_pkg SHALL hold SCORE_W=10, NUM_DIGITS=4, the FSM state enum, the digit-to-segment constants, and SEG_BLANK=7'b1111111.
REQ-028 Sub-module seg7_decode (4-bit digit in, 7-bit active-low out, combinational) SHALL be instantiated once per digit.
REQ-029 The FSM, the iteration counter, and the BCD datapath SHALL reside in score_display.

Verification
REQ-030 rst, score=0 -> after 13 cycles hex0=1000000, hex1..hex3=1111111, busy=0.
REQ-031 score=0 then 1023 -> busy high for exactly 12 cycles; then hex3..hex0 show 1,0,2,3.
REQ-032 score 5->6 on the 4th SHIFT cycle -> 5 is shown briefly, then 6 after the restart; no other value is shown.
REQ-033 rst asserted in SHIFT with score=999 -> outputs return to reset values the next cycle; after release, 999 is displayed within 13 cycles.
REQ-034 Macro defined: score ramps to 57, then screen=1 with score=0 -> hi_score=57 and the display shows 57; then screen=0 -> the display shows 0.
REQ-035 BLANK_LZ=0, score=7 -> hex3..hex1=1000000, hex0=1111000.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants and types for the score display block.
//   SCORE_W    : width of the binary score
//   NUM_DIGITS : number of decimal digits shown
//   state_e    : conversion FSM states
//   SEG_*      : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
package score_pkg;

    localparam int unsigned SCORE_W    = 10;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StLatch
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a nibble >= 5 would exceed 9 after the shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   digit_i : BCD digit 0..9 (codes 10..15 show blank)
//   seg_o   : segments {g,f,e,d,c,b,a}, active low
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Converts a 10-bit score to four 7-segment digits using a sequential
// double-dabble converter (one bit per cycle) and tracks the best score.
//
// Optional feature: define SCORE_DISPLAY_HIGH_SCORE_EN to keep a high score
// and show it while the start/game-over screen is up. Without it hi_score is 0
// and the display always follows score.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   score    : running score
//   screen   : high while the start/game-over screen is shown
//   hex0..3  : active-low segments {g,f,e,d,c,b,a}, hex0 = ones digit
//   busy     : high while a conversion is in progress
//   hi_score : best score since rst
module score_display
    import score_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1  // 1: blank leading zero digits (hex0 always shown)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               screen,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic               busy,
    output logic [SCORE_W-1:0] hi_score
);

    logic [SCORE_W-1:0] src;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    logic [SCORE_W-1:0] hi_q;

    // Not gated by screen: a score bump on the same cycle the screen comes up still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
        end else if (score > hi_q) begin
            hi_q <= score;
        end
    end

    assign hi_score = hi_q;
    assign src      = screen ? hi_q : score;
`else
    logic unused_screen;

    assign unused_screen = screen;
    assign hi_score      = '0;
    assign src           = score;
`endif

    state_e             state_q, state_d;
    logic               first_q, first_d;   // forces one conversion after reset
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] conv_q, conv_d;     // value being converted
    logic [SCORE_W-1:0] last_q, last_d;     // value currently on the display
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [BCD_W-1:0]   bcd_adj;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        conv_d   = conv_q;
        last_d   = last_q;
        digits_d = digits_q;
        case (state_q)
            StIdle: begin
                if (first_q || (src != last_q)) begin
                    state_d = StLoad;
                    first_d = 1'b0;
                end
            end
            StLoad: begin
                bin_d   = src;
                conv_d  = src;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(SCORE_W - 1)) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                digits_d = bcd_q;
                last_d   = conv_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            first_q  <= 1'b1;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            conv_q   <= '0;
            last_q   <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            conv_q   <= conv_d;
            last_q   <= last_d;
            digits_q <= digits_d;
        end
    end

    assign busy = (state_q != StIdle);

    logic [6:0] seg_raw [NUM_DIGITS];
    logic [6:0] seg_out [NUM_DIGITS];

    for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_digit
        seg7_decode u_dec (
            .digit_i (digits_q[4*k +: 4]),
            .seg_o   (seg_raw[k])
        );
        if (BLANK_LZ && (k != 0)) begin : g_blank
            // Blank while this digit and every higher one is zero.
            assign seg_out[k] = (digits_q[BCD_W-1:4*k] == '0) ? SEG_BLANK : seg_raw[k];
        end else begin : g_show
            assign seg_out[k] = seg_raw[k];
        end
    end

    assign hex0 = seg_out[0];
    assign hex1 = seg_out[1];
    assign hex2 = seg_out[2];
    assign hex3 = seg_out[3];

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] score = '0;
    logic       screen = 1'b0;

    logic [6:0] hex0, hex1, hex2, hex3;
    logic [6:0] nb_hex0, nb_hex1, nb_hex2, nb_hex3;
    logic       busy, nb_busy;
    logic [9:0] hi_score, nb_hi_score;

    int vectors = 0;
    int miscompares = 0;
    int hi_m = 0;

    always #5 clk = ~clk;

    score_display #(.BLANK_LZ(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .screen   (screen),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .busy     (busy),
        .hi_score (hi_score)
    );

    score_display #(.BLANK_LZ(1'b0)) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .screen   (screen),
        .hex0     (nb_hex0),
        .hex1     (nb_hex1),
        .hex2     (nb_hex2),
        .hex3     (nb_hex3),
        .busy     (nb_busy),
        .hi_score (nb_hi_score)
    );

    wire [27:0] disp    = {hex3, hex2, hex1, hex0};
    wire [27:0] disp_nb = {nb_hex3, nb_hex2, nb_hex1, nb_hex0};

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Expected {hex3,hex2,hex1,hex0} for decimal value v.
    function automatic logic [27:0] exp_disp(input int v, input bit blank);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (blank && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
            else                         r[7*k +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int src_m();
        return (HI_EN && screen) ? hi_m : int'(score);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_score(input int v);
        score = 10'(v);
        if (HI_EN && v > hi_m) hi_m = v;
    endtask

    task automatic check_display(input string name, input int v);
        logic [27:0] e, enb;
        e   = exp_disp(v, 1'b1);
        enb = exp_disp(v, 1'b0);
        vectors++;
        if (disp !== e) begin
            miscompares++;
            $display("FAIL %s: display got %h want %h (value %0d)", name, disp, e, v);
        end
        vectors++;
        if (disp_nb !== enb) begin
            miscompares++;
            $display("FAIL %s: no-blank display got %h want %h (value %0d)", name, disp_nb, enb, v);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (busy !== 1'b0 || nb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: busy got %b/%b want 0", name, busy, nb_busy);
        end
        vectors++;
        if (hi_score !== 10'(hi_m) || nb_hi_score !== 10'(hi_m)) begin
            miscompares++;
            $display("FAIL %s: hi_score got %0d/%0d want %0d", name, hi_score, nb_hi_score, hi_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        screen = 1'b0;
        score = '0;
        step(1);
        rst = 1'b0;
        hi_m = 0;
        vectors++;
        if (disp !== {7'h7f, 7'h7f, 7'h7f, 7'b1000000} || busy !== 1'b0 || hi_score !== '0) begin
            miscompares++;
            $display("FAIL reset_values: display %h busy %b hi %0d want 7f7f7f40-pattern/0/0",
                     disp, busy, hi_score);
        end
        vectors++;
        if (disp_nb !== {4{7'b1000000}}) begin
            miscompares++;
            $display("FAIL reset_no_blank: got %h want %h", disp_nb, {4{7'b1000000}});
        end
        for (int k = 1; k <= 13; k++) begin
            step(1);
            vectors++;
            if (busy !== (k <= 12)) begin
                miscompares++;
                $display("FAIL reset_conv_busy: step %0d busy %b want %b", k, busy, k <= 12);
            end
        end
        check_display("reset_conv", 0);
        check_idle("reset_conv");
    endtask

    task automatic test_max();
        int busy_cnt;
        busy_cnt = 0;
        set_score(1023);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (busy) busy_cnt++;
            if (k == 12) check_display("max_before_latency", 0);
            if (k == 13) check_display("max_at_latency", 1023);
        end
        vectors++;
        if (busy_cnt != 12) begin
            miscompares++;
            $display("FAIL max_busy_len: got %0d cycles want 12", busy_cnt);
        end
        check_idle("max");
    endtask

    task automatic test_restart();
        set_score(5);
        step(5);          // now in the 4th SHIFT cycle
        set_score(6);
        for (int k = 6; k <= 30; k++) begin
            step(1);
            if (k < 13)      check_display("restart_old", 1023);
            else if (k < 26) check_display("restart_five", 5);
            else             check_display("restart_six", 6);
        end
        check_idle("restart");
    endtask

    task automatic test_rst_mid();
        set_score(999);
        step(6);
        rst = 1'b1;
        step(1);
        hi_m = 0;
        vectors++;
        if (disp !== {7'h7f, 7'h7f, 7'h7f, 7'b1000000} || busy !== 1'b0 || hi_score !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_values: display %h busy %b hi %0d", disp, busy, hi_score);
        end
        rst = 1'b0;
        set_score(999);
        step(13);
        check_display("rst_mid_recover", 999);
        check_idle("rst_mid_recover");
    endtask

    task automatic test_no_blank();
        set_score(7);
        step(15);
        vectors++;
        if (disp_nb !== {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}) begin
            miscompares++;
            $display("FAIL no_blank_7: got %h want %h", disp_nb,
                     {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
        end
        check_display("no_blank_7", 7);
    endtask

    task automatic test_screen();
        if (HI_EN) begin
            rst = 1'b1;
            set_score(0);
            step(1);
            rst = 1'b0;
            hi_m = 0;
            for (int v = 1; v <= 57; v++) begin
                set_score(v);
                step(1);
            end
            step(30);
            check_display("hi_ramp", 57);
            check_idle("hi_ramp");
            screen = 1'b1;
            set_score(0);
            step(30);
            check_display("hi_screen", 57);
            check_idle("hi_screen");
            screen = 1'b0;
            step(30);
            check_display("hi_screen_off", 0);
            check_idle("hi_screen_off");
        end else begin
            screen = 1'b1;
            set_score(57);
            step(30);
            check_display("screen_ignored", 57);
            check_idle("screen_ignored");
            set_score(3);
            step(30);
            check_display("screen_ignored2", 3);
            check_idle("screen_ignored2");
            screen = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            screen = 1'($urandom_range(0, 1));
            set_score(int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 1) == 1) begin
                step(int'($urandom_range(1, 12)));
                set_score(int'($urandom_range(0, 1023)));
            end
            step(32);
            check_display("random", src_m());
            check_idle("random");
        end
        screen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max();
        test_restart();
        test_rst_mid();
        test_no_blank();
        test_screen();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
